// File: rtl/trap_sequencer_pkg.sv
// Purpose : shared types and constants for machine-mode trap sequencing.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, PC-select encoding, exception request bit
//           indices, mcause codes and the mtval selection helper.
package trap_sequencer_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ENTER    = 2'b01,
      ST_REDIRECT = 2'b10,
      ST_RETURN   = 2'b11
   } trap_state_t;

   typedef enum logic [1:0] {
      PC_NORMAL = 2'b00,
      PC_MTVEC  = 2'b01,
      PC_MEPC   = 2'b10
   } pc_sel_t;

   // Bit positions inside exc_req_i
   localparam int EXC_INSTR_MISALIGN = 0;
   localparam int EXC_ILLEGAL        = 1;
   localparam int EXC_EBREAK         = 2;
   localparam int EXC_ECALL          = 3;
   localparam int EXC_LOAD_MISALIGN  = 4;
   localparam int EXC_STORE_MISALIGN = 5;

   // mcause values
   localparam logic [31:0] CAUSE_INSTR_MISALIGN = 32'd0;
   localparam logic [31:0] CAUSE_ILLEGAL        = 32'd2;
   localparam logic [31:0] CAUSE_BREAKPOINT     = 32'd3;
   localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
   localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
   localparam logic [31:0] CAUSE_ECALL          = 32'd11;
   localparam logic [31:0] CAUSE_MTIMER_IRQ     = 32'h8000_0007;

   // mtval for a synchronous exception, chosen from its cause code.
   function automatic logic [31:0] trap_value(input logic [31:0] cause,
                                              input logic [31:0] instr,
                                              input logic [31:0] pc,
                                              input logic [31:0] badaddr);
      logic [31:0] val;
      val = 32'd0;
      case (cause)
         CAUSE_ILLEGAL:        val = instr;
         CAUSE_INSTR_MISALIGN,
         CAUSE_LOAD_MISALIGN,
         CAUSE_STORE_MISALIGN: val = badaddr;
         CAUSE_BREAKPOINT:     val = pc;
         default:              val = 32'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/trap_sequencer_priority_enc.sv
// Purpose : fixed-priority pick among synchronous exception requests.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of exc_req_i.
// Ports   : exc_req_i (6 request bits in) -> valid_o (any request),
//           cause_o (mcause of the winning request).
// Priority: ebreak > ecall > illegal > instr misaligned > store misaligned > load misaligned.
module trap_priority_enc
   import trap_sequencer_pkg::*;
(
   input  logic [5:0]  exc_req_i,
   output logic        valid_o,
   output logic [31:0] cause_o
);

   always_comb begin
      valid_o = |exc_req_i;
      cause_o = CAUSE_INSTR_MISALIGN;
      if (exc_req_i[EXC_EBREAK])              cause_o = CAUSE_BREAKPOINT;
      else if (exc_req_i[EXC_ECALL])          cause_o = CAUSE_ECALL;
      else if (exc_req_i[EXC_ILLEGAL])        cause_o = CAUSE_ILLEGAL;
      else if (exc_req_i[EXC_INSTR_MISALIGN]) cause_o = CAUSE_INSTR_MISALIGN;
      else if (exc_req_i[EXC_STORE_MISALIGN]) cause_o = CAUSE_STORE_MISALIGN;
      else if (exc_req_i[EXC_LOAD_MISALIGN])  cause_o = CAUSE_LOAD_MISALIGN;
   end

endmodule

// File: rtl/trap_sequencer.sv
// Purpose : sequences M-mode trap entry (-> mtvec) and MRET (-> mepc) around the CSR unit.
// Latency : trap request at N -> CSR capture strobe N+1 -> mtvec redirect N+2 -> idle N+3;
//           MRET at N -> mepc redirect N+1 -> idle N+2.
// Backpressure: stall_o holds the pipeline on the accept cycle and through ENTER;
//           requests arriving outside IDLE are ignored (irq_i stays level-pending).
// Ports   : clk, rst_n (async active-low); exc_req_i/mret_i/irq_i requests;
//           pc_i/instr_i/badaddr_i trap context; stall_o/flush_o/pc_sel_o pipeline
//           control; jumpingToMtvec_o/excCause_o/trapInfo_o/trapPc_o/mret_o to CSR unit.
// Option  : define TRAP_COUNTER_EN to add trap_count_o (count of trap entries).
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [5:0]      exc_req_i,
   input  logic            mret_i,
   input  logic            irq_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] badaddr_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic [1:0]      pc_sel_o,
   output logic            jumpingToMtvec_o,
   output logic [31:0]     excCause_o,
   output logic [31:0]     trapInfo_o,
   output logic [XLEN-1:0] trapPc_o,
`ifdef TRAP_COUNTER_EN
   output logic [31:0]     trap_count_o,
`endif
   output logic            mret_o
);

   trap_state_t     state_q, state_d;
   logic [31:0]     cause_q, cause_d;
   logic [31:0]     info_q,  info_d;
   logic [XLEN-1:0] pc_q,    pc_d;

   logic        exc_vld;
   logic [31:0] exc_cause;
   logic [31:0] exc_info;
   logic        req_any;

   trap_priority_enc u_prio (
      .exc_req_i (exc_req_i),
      .valid_o   (exc_vld),
      .cause_o   (exc_cause)
   );

   assign exc_info = trap_value(exc_cause, instr_i, 32'(pc_i), 32'(badaddr_i));
   assign req_any  = exc_vld | mret_i | irq_i;

   // State and capture registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cause_q <= '0;
         info_q  <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         info_q  <= info_d;
         pc_q    <= pc_d;
      end
   end

   // Next state and capture; sync exception beats MRET beats interrupt.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      info_d  = info_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_vld) begin
               state_d = ST_ENTER;
               cause_d = exc_cause;
               info_d  = exc_info;
               pc_d    = pc_i;
            end else if (mret_i) begin
               state_d = ST_RETURN;
            end else if (irq_i) begin
               state_d = ST_ENTER;
               cause_d = CAUSE_MTIMER_IRQ;
               info_d  = 32'd0;
               pc_d    = pc_i;
            end
         end
         ST_ENTER:    state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_IDLE;
         ST_RETURN:   state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Outputs. stall_o is gated by rst_n so every output reads 0 while reset is held.
   always_comb begin
      stall_o          = 1'b0;
      flush_o          = 1'b0;
      pc_sel_o         = PC_NORMAL;
      jumpingToMtvec_o = 1'b0;
      mret_o           = 1'b0;
      case (state_q)
         ST_IDLE:     stall_o = rst_n & req_any;
         ST_ENTER: begin
            stall_o          = 1'b1;
            jumpingToMtvec_o = 1'b1;
         end
         ST_REDIRECT: begin
            pc_sel_o = PC_MTVEC;
            flush_o  = 1'b1;
         end
         ST_RETURN: begin
            pc_sel_o = PC_MEPC;
            flush_o  = 1'b1;
            mret_o   = 1'b1;
         end
         default: ;
      endcase
   end

   assign excCause_o = cause_q;
   assign trapInfo_o = info_q;
   assign trapPc_o   = pc_q;

`ifdef TRAP_COUNTER_EN
   logic [31:0] trap_count_q, trap_count_d;

   // One increment per ENTER cycle; wraps naturally at 32 bits.
   always_comb begin
      trap_count_d = trap_count_q;
      if (state_q == ST_ENTER) trap_count_d = trap_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trap_count_q <= '0;
      else        trap_count_q <= trap_count_d;
   end

   assign trap_count_o = trap_count_q;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Purpose : directed self-checking bench for trap_sequencer.
// Latency : inputs driven on the falling edge, outputs sampled on falling edges.
// Backpressure: n/a.
module tb_trap_sequencer;

   logic        clk;
   logic        rst_n;
   logic [5:0]  exc_req_i;
   logic        mret_i;
   logic        irq_i;
   logic [31:0] pc_i;
   logic [31:0] instr_i;
   logic [31:0] badaddr_i;
   logic        stall_o;
   logic        flush_o;
   logic [1:0]  pc_sel_o;
   logic        jumpingToMtvec_o;
   logic [31:0] excCause_o;
   logic [31:0] trapInfo_o;
   logic [31:0] trapPc_o;
   logic        mret_o;
`ifdef TRAP_COUNTER_EN
   logic [31:0] trap_count_o;
`endif

   int tests_run;
   int tests_failed;

   trap_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .exc_req_i        (exc_req_i),
      .mret_i           (mret_i),
      .irq_i            (irq_i),
      .pc_i             (pc_i),
      .instr_i          (instr_i),
      .badaddr_i        (badaddr_i),
      .stall_o          (stall_o),
      .flush_o          (flush_o),
      .pc_sel_o         (pc_sel_o),
      .jumpingToMtvec_o (jumpingToMtvec_o),
      .excCause_o       (excCause_o),
      .trapInfo_o       (trapInfo_o),
      .trapPc_o         (trapPc_o),
`ifdef TRAP_COUNTER_EN
      .trap_count_o     (trap_count_o),
`endif
      .mret_o           (mret_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; exc_req_i = '0; mret_i = 0; irq_i = 0;
      pc_i = '0; instr_i = '0; badaddr_i = '0;
      tick(); tick();
      tests_run++;
      if ({stall_o, flush_o, pc_sel_o, jumpingToMtvec_o, mret_o} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 000000", {stall_o, flush_o, pc_sel_o, jumpingToMtvec_o, mret_o});
      end
      tests_run++;
      if ({excCause_o, trapInfo_o, trapPc_o} !== 96'd0) begin
         tests_failed++;
         $display("FAIL reset_capture: got %h %h %h expected zeros", excCause_o, trapInfo_o, trapPc_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_illegal();
      exc_req_i = 6'b000010; pc_i = 32'h100; instr_i = 32'hFFFF_FFFF; badaddr_i = 32'hDEAD;
      #1;
      tests_run++;
      if ({stall_o, jumpingToMtvec_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL illegal_N_stall: got %b expected 10", {stall_o, jumpingToMtvec_o});
      end
      tick();  // N+1: ENTER
      exc_req_i = '0;
      tests_run++;
      if ({jumpingToMtvec_o, stall_o, pc_sel_o, flush_o} !== 5'b11000) begin
         tests_failed++;
         $display("FAIL illegal_enter_ctrl: got %b expected 11000", {jumpingToMtvec_o, stall_o, pc_sel_o, flush_o});
      end
      tests_run++;
      if (excCause_o !== 32'd2 || trapInfo_o !== 32'hFFFF_FFFF || trapPc_o !== 32'h100) begin
         tests_failed++;
         $display("FAIL illegal_capture: got %h %h %h expected 2 ffffffff 100", excCause_o, trapInfo_o, trapPc_o);
      end
      tick();  // N+2: REDIRECT
      tests_run++;
      if ({pc_sel_o, flush_o, jumpingToMtvec_o, stall_o} !== 5'b01100) begin
         tests_failed++;
         $display("FAIL illegal_redirect: got %b expected 01100", {pc_sel_o, flush_o, jumpingToMtvec_o, stall_o});
      end
      tick();  // N+3: IDLE, captured values retained
      tests_run++;
      if ({pc_sel_o, flush_o} !== 3'b000 || excCause_o !== 32'd2) begin
         tests_failed++;
         $display("FAIL illegal_idle: got %b cause %h expected 000 cause 2", {pc_sel_o, flush_o}, excCause_o);
      end
   endtask

   task automatic test_priority();
      logic [5:0]  req_tab   [6] = '{6'b000001, 6'b010000, 6'b110000, 6'b001010, 6'b001110, 6'b100001};
      logic [31:0] cause_tab [6] = '{32'd0, 32'd4, 32'd6, 32'd11, 32'd3, 32'd0};
      logic [31:0] info_tab  [6] = '{32'h2003, 32'h2003, 32'h2003, 32'h0, 32'h1000, 32'h2003};
      for (int i = 0; i < 6; i++) begin
         exc_req_i = req_tab[i]; pc_i = 32'h1000; instr_i = 32'h0010_0073; badaddr_i = 32'h2003;
         irq_i = (i == 4);
         tick();  // ENTER
         exc_req_i = '0;
         tests_run++;
         if (excCause_o !== cause_tab[i] || trapInfo_o !== info_tab[i] || jumpingToMtvec_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL priority_%0d: got cause %h info %h jmp %b expected %h %h 1",
                     i, excCause_o, trapInfo_o, jumpingToMtvec_o, cause_tab[i], info_tab[i]);
         end
         tick();  // REDIRECT (irq still held but ignored)
         irq_i = 0;
         tests_run++;
         if (pc_sel_o !== 2'b01) begin
            tests_failed++;
            $display("FAIL priority_%0d_redirect: got %b expected 01", i, pc_sel_o);
         end
         tick();  // IDLE
      end
   endtask

   task automatic test_timer();
      irq_i = 1; pc_i = 32'h2000; instr_i = 32'h1234_5678; badaddr_i = 32'h77;
      #1;
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL timer_N_stall: got %b expected 1", stall_o);
      end
      tick();  // ENTER; CSR clears mie here
      irq_i = 0;
      tests_run++;
      if (excCause_o !== 32'h8000_0007 || trapInfo_o !== 32'd0 || trapPc_o !== 32'h2000) begin
         tests_failed++;
         $display("FAIL timer_capture: got %h %h %h expected 80000007 0 2000", excCause_o, trapInfo_o, trapPc_o);
      end
      tick();  // REDIRECT
      tick();  // IDLE with irq low
      tests_run++;
      if (stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL timer_no_rearm_stall: got %b expected 0", stall_o);
      end
      tick();
      tests_run++;
      if ({jumpingToMtvec_o, pc_sel_o} !== 3'b000) begin
         tests_failed++;
         $display("FAIL timer_no_second_entry: got %b expected 000", {jumpingToMtvec_o, pc_sel_o});
      end
   endtask

   task automatic test_mret();
      mret_i = 1;
      #1;
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL mret_N_stall: got %b expected 1", stall_o);
      end
      tick();  // RETURN
      mret_i = 0;
      tests_run++;
      if ({pc_sel_o, mret_o, flush_o, stall_o, jumpingToMtvec_o} !== 6'b101100) begin
         tests_failed++;
         $display("FAIL mret_return: got %b expected 101100", {pc_sel_o, mret_o, flush_o, stall_o, jumpingToMtvec_o});
      end
      tick();  // IDLE
      tests_run++;
      if ({mret_o, pc_sel_o, flush_o} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL mret_done: got %b expected 0000", {mret_o, pc_sel_o, flush_o});
      end
   endtask

   task automatic test_mret_vs_irq();
      mret_i = 1; irq_i = 1; pc_i = 32'h3000;
      tick();  // RETURN wins over irq
      mret_i = 0;
      tests_run++;
      if ({mret_o, jumpingToMtvec_o} !== 2'b10) begin
         tests_failed++;
         $display("FAIL mret_irq_order: got %b expected 10", {mret_o, jumpingToMtvec_o});
      end
      tick();  // IDLE at N+2: pending irq accepted
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL mret_irq_accept: got %b expected 1", stall_o);
      end
      tick();  // ENTER
      irq_i = 0;
      tests_run++;
      if (jumpingToMtvec_o !== 1'b1 || excCause_o !== 32'h8000_0007 || trapPc_o !== 32'h3000) begin
         tests_failed++;
         $display("FAIL mret_irq_enter: got %b %h %h expected 1 80000007 3000", jumpingToMtvec_o, excCause_o, trapPc_o);
      end
      tick(); tick();
   endtask

   task automatic test_reset_in_enter();
      exc_req_i = 6'b000100; pc_i = 32'h440;
      tick();  // ENTER, request still held
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({stall_o, flush_o, pc_sel_o, jumpingToMtvec_o, mret_o} !== 6'b0 ||
          {excCause_o, trapInfo_o, trapPc_o} !== 96'd0) begin
         tests_failed++;
         $display("FAIL reset_enter_clear: got %b %h %h %h expected all zero",
                  {stall_o, flush_o, pc_sel_o, jumpingToMtvec_o, mret_o}, excCause_o, trapInfo_o, trapPc_o);
      end
      tick();
      exc_req_i = '0;
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if ({pc_sel_o, flush_o, jumpingToMtvec_o, stall_o} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_enter_idle: got %b expected 00000", {pc_sel_o, flush_o, jumpingToMtvec_o, stall_o});
      end
      tick();
      tests_run++;
      if ({pc_sel_o, flush_o, jumpingToMtvec_o} !== 4'b0) begin
         tests_failed++;
         $display("FAIL reset_enter_no_action: got %b expected 0000", {pc_sel_o, flush_o, jumpingToMtvec_o});
      end
   endtask

`ifdef TRAP_COUNTER_EN
   task automatic test_counter();
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         exc_req_i = 6'b001000;
         tick(); exc_req_i = '0; tick(); tick();
      end
      mret_i = 1; tick(); mret_i = 0; tick();
      tests_run++;
      if (trap_count_o !== 32'd3) begin
         tests_failed++;
         $display("FAIL counter_three: got %h expected 3", trap_count_o);
      end
      force dut.trap_count_q = 32'hFFFF_FFFF;
      #1 release dut.trap_count_q;
      exc_req_i = 6'b001000;
      tick(); exc_req_i = '0; tick();  // REDIRECT: increment has landed
      tests_run++;
      if (trap_count_o !== 32'd0) begin
         tests_failed++;
         $display("FAIL counter_wrap: got %h expected 0", trap_count_o);
      end
      tick();
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_illegal();
      test_priority();
      test_timer();
      test_mret();
      test_mret_vs_irq();
      test_reset_in_enter();
`ifdef TRAP_COUNTER_EN
      test_counter();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences machine-mode trap entry and return around the CSR unit. Arbitrates synchronous exception requests from the controller against the pending timer interrupt, then drives the CSR unit's trap-capture inputs (jump strobe, cause, trap value, PC). It also steers the fetch PC to mtvec or mepc and stalls/flushes the pipeline for the duration. It sits between the main controller, the CSR unit and the PC mux.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- exc_req_i  in  6  sync exception requests: [0] instr misaligned, [1] illegal, [2] ebreak, [3] ecall, [4] load misaligned, [5] store misaligned
- mret_i  in  1  MRET decoded in execute
- irq_i  in  1  timer interrupt pending and enabled (CSR unit mtime_exc)
- pc_i  in  XLEN  PC of instruction in execute
- instr_i  in  32  instruction word in execute
- badaddr_i  in  XLEN  faulting address (jump target or load/store address)
- stall_o  out  1  hold pipeline; reset 0
- flush_o  out  1  kill fetched/decoded instruction; reset 0
- pc_sel_o  out  2  00 normal, 01 mtvec, 10 mepc; reset 00
- jumpingToMtvec_o  out  1  one-cycle CSR capture strobe; reset 0
- excCause_o  out  32  mcause value; reset 0
- trapInfo_o  out  32  mtval value; reset 0
- trapPc_o  out  XLEN  mepc value; reset 0
- mret_o  out  1  one-cycle return strobe to CSR unit; reset 0

## Operation
- FSM states: IDLE, ENTER, REDIRECT, RETURN. Reset (rst_n low, any time) forces IDLE, clears all outputs and captured registers.
- IDLE: if any exc_req_i bit set, selects the winner by fixed priority ebreak > ecall > illegal > instr misaligned > store misaligned > load misaligned. Captures cause/info/pc and goes to ENTER. Else if mret_i, goes to RETURN. Else if irq_i, captures cause 0x8000_0007, info 0, pc_i, and goes to ENTER.
- Simultaneous events: sync exception beats mret_i beats irq_i. The losing irq_i stays level-pending and is re-evaluated only in IDLE.
- Cause codes: instr misaligned 0, illegal 2, ebreak 3, load misaligned 4, store misaligned 6, ecall 11.
- trapInfo: illegal -> instr_i; any misaligned -> badaddr_i; ebreak -> pc_i; ecall and interrupt -> 0.
- ENTER: jumpingToMtvec_o=1 and excCause_o/trapInfo_o/trapPc_o hold the captured values; next state REDIRECT.
- REDIRECT: pc_sel_o=01, flush_o=1; next state IDLE.
- RETURN: pc_sel_o=10, flush_o=1, mret_o=1; next state IDLE.
- All request inputs are ignored outside IDLE. excCause_o/trapInfo_o/trapPc_o keep their last captured value until the next capture.

## Timing
- stall_o is combinational: 1 in IDLE when any request is accepted (cycle N), and 1 throughout ENTER. Otherwise 0. The trapping instruction never commits.
- Trap entry: request at N; ENTER at N+1 (CSR unit captures at the end of N+1, clearing mstatus.mie); REDIRECT at N+2 (PC loads mtvec at the end of N+2); IDLE at N+3.
- Because mie is cleared at the end of N+1, irq_i must already be low in IDLE at N+3. A back-to-back interrupt is not possible unless the handler re-enables it.
- Return: mret_i at N; RETURN at N+1; IDLE at N+2, where a pending irq_i may be accepted.
- Minimum spacing between two accepted trap entries: 3 cycles.

## Configuration
- TRAP_COUNTER_EN defined: adds output trap_count_o (32 bits, reset 0).
  - Increments by 1 on every cycle in ENTER and wraps 0xFFFF_FFFF -> 0.
  - Unchanged on RETURN.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package: trap_state_t enum, pc_sel_t (PC_NORMAL/PC_MTVEC/PC_MEPC), exception request index localparams, cause constants (CAUSE_* and CAUSE_MTIMER_IRQ = 0x8000_0007).
- One sub-module: trap_priority_enc. Combinational; takes exc_req_i and returns a valid bit and the 32-bit cause.
- FSM, capture registers and optional counter live in trap_sequencer.

## Test plan
- Illegal: exc_req_i=6'b000010, pc_i=0x100, instr_i=0xFFFF_FFFF -> N+1: jumpingToMtvec_o=1, excCause_o=2, trapInfo_o=0xFFFF_FFFF, trapPc_o=0x100; N+2: pc_sel_o=01, flush_o=1.
- Priority: exc_req_i=6'b001110 with irq_i=1 -> excCause_o=3 (ebreak), trapInfo_o=pc_i; irq ignored until IDLE.
- Timer: irq_i=1 only, pc_i=0x2000 -> excCause_o=0x8000_0007, trapInfo_o=0, trapPc_o=0x2000; N+3 with irq_i=0 -> no second entry.
- MRET: mret_i=1 -> N+1: pc_sel_o=10, mret_o=1, flush_o=1, stall_o=0; mret_o low again at N+2.
- Reset: rst_n low during ENTER -> all outputs 0 immediately, FSM in IDLE after release; requests held during ENTER are not acted on.
- TRAP_COUNTER_EN: 3 traps and 1 MRET -> trap_count_o=3; preload 0xFFFF_FFFF via force, then 1 trap -> 0.
